alu_sync_ram: RTL and testbench

Datapath building block for the accumulator CPU: a 32-bit combinational ALU with a 4-bit operation select, plus a single-port synchronous RAM. The RAM has a bidirectional tri-state data bus, chip select, write enable and output enable. The CPU sequencer drives MAR onto `addr`, moves words over `data`, and feeds AC/MBR into the ALU. Program and data (instructions, Fibonacci operands, constants) live in the RAM.

---
 rtl/alu_sync_ram_if.sv | 26 ++
 rtl/alu_sync_ram.sv | 93 +++++++++
 tb/tb_alu_sync_ram.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sync_ram_if.sv
// Control, address and ALU operand/result signals between the CPU sequencer and alu_sync_ram.
// The tri-state data bus is a separate inout port of the block.
interface alu_sync_ram_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cs_input;
    logic                  we;
    logic                  oe;
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
    logic [3:0]            alu_sel;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_zero;

    modport master (
        output addr, cs_input, we, oe, left, right, alu_sel,
        input  alu_out, alu_zero
    );

    modport slave (
        input  addr, cs_input, we, oe, left, right, alu_sel,
        output alu_out, alu_zero
    );
endinterface

// File: rtl/alu_sync_ram.sv
// 32-bit combinational ALU plus single-port synchronous RAM with a tri-state data bus,
// the datapath core of the accumulator CPU.
module alu_sync_ram #(
    parameter int ADDR_WIDTH    = 28,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    alu_sync_ram_if.slave         bus,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_PASS_L = 4'b1011;
    localparam logic [3:0] OP_PASS_R = 4'b1100;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [MEM_ADDR_BITS-1:0] mem_idx;
    logic [ADDR_WIDTH-MEM_ADDR_BITS-1:0] unused_addr_hi;
    logic                     wr_en;
    logic                     drive_en;
    logic [DATA_WIDTH-1:0]    rd_d, rd_q;

    // Upper address bits are ignored so addresses alias modulo the implemented depth.
    assign mem_idx        = bus.addr[MEM_ADDR_BITS-1:0];
    assign unused_addr_hi = bus.addr[ADDR_WIDTH-1:MEM_ADDR_BITS];

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_en    = 1'b0;
        drive_en = 1'b0;
        rd_d     = rd_q;
        if (bus.cs_input) begin
            if (bus.we) wr_en = ~reset;
            else        rd_d  = mem[mem_idx];
        end
        drive_en = bus.cs_input & bus.oe & ~bus.we;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    // NOTE: the storage array has no reset; contents survive reset and a clear would block RAM inference.
    always_ff @(posedge clock) begin
        if (wr_en) mem[mem_idx] <= data;
    end

    // Never driven while we=1, so the external writer owns the bus during writes.
    assign data = drive_en ? rd_q : 'z;

    logic [DATA_WIDTH-1:0] alu_result;
    logic [4:0]            shamt;

    assign shamt = bus.right[4:0];

    always_comb begin
        alu_result = '0;
        unique case (bus.alu_sel)
            OP_AND:    alu_result = bus.left & bus.right;
            OP_OR:     alu_result = bus.left | bus.right;
            OP_ADD:    alu_result = bus.left + bus.right;
            OP_XOR:    alu_result = bus.left ^ bus.right;
            OP_SLL:    alu_result = bus.left << shamt;
            OP_SRL:    alu_result = bus.left >> shamt;
            OP_SUB:    alu_result = bus.left - bus.right;
            OP_SLT:    alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.left) < $signed(bus.right)};
            OP_SRA:    alu_result = $unsigned($signed(bus.left) >>> shamt);
            OP_SLTU:   alu_result = {{(DATA_WIDTH-1){1'b0}}, bus.left < bus.right};
            OP_NOR:    alu_result = ~(bus.left | bus.right);
            OP_PASS_L: alu_result = bus.left;
            OP_PASS_R: alu_result = bus.right;
            default:   alu_result = '0;
        endcase
    end

    assign bus.alu_out  = alu_result;
    assign bus.alu_zero = (alu_result == '0);
endmodule

// File: tb/tb_alu_sync_ram.sv
// Self-checking bench for alu_sync_ram: directed test-plan steps followed by randomized
// RAM and ALU traffic compared against an array/arithmetic reference model.
module tb_alu_sync_ram;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int MB = 12;

    logic clock = 1'b0;
    logic reset;
    logic drv_en;
    logic [DW-1:0] drv_val;
    wire  [DW-1:0] data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] ref_mem [1 << MB];
    int            written [$];
    logic [DW-1:0] last_rd;

    alu_sync_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    alu_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_BITS(MB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave),
        .data  (data)
    );

    assign data = drv_en ? drv_val : 'z;

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
        bus_if.cs_input = 1'b1;
        bus_if.we       = 1'b1;
        bus_if.oe       = 1'b0;
        bus_if.addr     = a;
        drv_val         = v;
        drv_en          = 1'b1;
        tick();
        drv_en    = 1'b0;
        bus_if.we = 1'b0;
        ref_mem[int'(a % (1 << MB))] = v;
        written.push_back(int'(a % (1 << MB)));
    endtask

    // Issues a read, clocks once, and checks the bus against the model one edge later.
    task automatic ram_read(input string tag, input logic [AW-1:0] a);
        bus_if.cs_input = 1'b1;
        bus_if.we       = 1'b0;
        bus_if.oe       = 1'b1;
        bus_if.addr     = a;
        tick();
        last_rd = ref_mem[int'(a % (1 << MB))];
        check(tag, data, last_rd);
    endtask

    // With the RAM expected off, the bench drives a probe; any RAM drive corrupts it.
    task automatic check_released(input string tag);
        drv_val = ~last_rd;
        drv_en  = 1'b1;
        #1;
        check(tag, data, ~last_rd);
        drv_en = 1'b0;
        #1;
    endtask

    function automatic logic [DW-1:0] alu_model(input logic [3:0] sel, input logic [DW-1:0] l,
                                                input logic [DW-1:0] r);
        logic [2*DW-1:0] ext;
        int sh;
        sh = int'(r % 32);
        case (sel)
            4'd0:  return l & r;
            4'd1:  return l | r;
            4'd2:  return l + r;
            4'd3:  return l ^ r;
            4'd4:  return l * (33'd1 << sh);
            4'd5:  return l / (33'd1 << sh);
            4'd6:  return l + ~r + 1;
            4'd7:  return (l[DW-1] != r[DW-1]) ? DW'(l[DW-1]) : DW'(l < r);
            4'd8: begin
                ext = {{DW{l[DW-1]}}, l};
                ext = ext / (64'd1 << sh);
                return ext[DW-1:0];
            end
            4'd9:  return DW'(l < r);
            4'd10: return ~l & ~r;
            4'd11: return l;
            4'd12: return r;
            default: return '0;
        endcase
    endfunction

    task automatic alu_check(input string tag, input logic [3:0] sel, input logic [DW-1:0] l,
                             input logic [DW-1:0] r);
        logic [DW-1:0] exp;
        bus_if.alu_sel = sel;
        bus_if.left    = l;
        bus_if.right   = r;
        #1;
        exp = alu_model(sel, l, r);
        check(tag, bus_if.alu_out, exp);
        check({tag, "_zero"}, DW'(bus_if.alu_zero), DW'(exp == '0));
    endtask

    initial begin
        logic [DW-1:0] op_a, op_b;
        logic [AW-1:0] ra;
        logic [DW-1:0] rv;
        int idx;

        drv_en  = 1'b0;
        drv_val = '0;
        last_rd = '0;
        reset   = 1'b1;
        bus_if.addr     = '0;
        bus_if.cs_input = 1'b1;
        bus_if.we       = 1'b0;
        bus_if.oe       = 1'b1;
        bus_if.left     = '0;
        bus_if.right    = '0;
        bus_if.alu_sel  = 4'd0;
        tick();
        tick();
        check("reset_rd", data, '0);
        reset = 1'b0;

        // Directed write then read-back, one edge of latency each
        ram_write(28'h100, 32'h2000_0113);
        ram_write(28'h101, 32'h0000_0111);
        ram_read("rd_0x100", 28'h100);
        ram_read("rd_0x101", 28'h101);

        // Operand reads feeding the adder
        ram_write(28'h111, 32'd0);
        ram_write(28'h112, 32'd1);
        ram_read("rd_d0", 28'h111);
        op_a = data;
        ram_read("rd_d1", 28'h112);
        op_b = data;
        alu_check("fib_add", 4'b0010, op_a, op_b);
        check("fib_add_val", bus_if.alu_out, 32'd1);
        alu_check("wrap_add", 4'b0010, 32'hFFFF_FFFF, 32'd1);
        check("wrap_add_zero", DW'(bus_if.alu_zero), 32'd1);

        // Bus release under each disabling condition, then the held word reappears
        ram_read("rd_hold", 28'h101);
        bus_if.oe = 1'b0;
        check_released("z_oe_low");
        bus_if.oe = 1'b1;
        bus_if.cs_input = 1'b0;
        check_released("z_cs_low");
        bus_if.cs_input = 1'b1;
        bus_if.we = 1'b1;
        check_released("z_we_high");
        bus_if.we = 1'b0;
        #1;
        check("oe_reassert", data, 32'h0000_0111);

        // Address aliasing modulo depth
        ram_write(28'h000_0100, 32'hDEAD_BEEF);
        ram_read("alias", 28'h000_1100);
        check("alias_val", data, 32'hDEAD_BEEF);

        // Reset clears the read register, discards an in-flight read, and blocks writes
        ram_write(28'h114, 32'd10);
        ram_read("rd_0x114", 28'h114);
        bus_if.addr = 28'h100;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_mid_read", data, '0);
        reset = 1'b1;
        bus_if.we = 1'b1;
        bus_if.oe = 1'b0;
        bus_if.addr = 28'h114;
        drv_val = 32'h0BAD_0BAD;
        drv_en  = 1'b1;
        tick();
        drv_en = 1'b0;
        bus_if.we = 1'b0;
        reset = 1'b0;
        ram_read("after_reset_0x114", 28'h114);
        check("after_reset_val", data, 32'd10);

        // Back-to-back reads, one word per cycle
        for (int i = 0; i < 4; i++) ram_write(28'h200 + AW'(i), 32'hA5A5_0000 + DW'(i * 7));
        for (int i = 0; i < 4; i++) ram_read("b2b", 28'h200 + AW'(i));

        // Read-after-write on the next cycle
        ram_write(28'h300, 32'h1234_5678);
        ram_read("raw", 28'h300);
        check("raw_val", data, 32'h1234_5678);

        // Directed ALU sweep
        alu_check("sub",  4'b0110, 32'h8000_0000, 32'd1);
        check("sub_val",  bus_if.alu_out, 32'h7FFF_FFFF);
        alu_check("slt",  4'b0111, 32'h8000_0000, 32'd1);
        check("slt_val",  bus_if.alu_out, 32'd1);
        alu_check("sltu", 4'b1001, 32'h8000_0000, 32'd1);
        check("sltu_val", bus_if.alu_out, 32'd0);
        alu_check("sra",  4'b1000, 32'h8000_0000, 32'd1);
        check("sra_val",  bus_if.alu_out, 32'hC000_0000);
        alu_check("srl",  4'b0101, 32'h8000_0000, 32'd1);
        check("srl_val",  bus_if.alu_out, 32'h4000_0000);
        alu_check("op_f", 4'b1111, 32'h8000_0000, 32'd1);
        check("op_f_val", bus_if.alu_out, 32'd0);

        // Randomized ALU traffic over every select value
        for (int i = 0; i < 64; i++) begin
            alu_check("alu_rand", 4'(i % 16), $urandom, (i % 3 == 0) ? DW'($urandom_range(0, 40)) : $urandom);
        end

        // Randomized RAM traffic with aliased upper address bits
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                ra = AW'($urandom);
                rv = $urandom;
                ram_write(ra, rv);
            end else begin
                idx = written[$urandom_range(0, written.size() - 1)];
                ra  = {AW'($urandom_range(0, (1 << (AW - MB)) - 1)) << MB} | AW'(idx);
                ram_read("ram_rand", ra);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
